flag_window_counter: RTL and testbench
======================================

Name: flag_window_counter

Overview:
Downstream consumer of the sequence-detector flag stage (fsm2 family); counts flag events over fixed windows of WIN_LEN cycles.
At each window end, publishes the count in a result register with valid/ready handshake.
Result holds a saturation indicator and a sticky dropped-result indicator.
Sits between the detector and the stats/CSR readout logic.

Parameters:
WIN_LEN, 16, window length in clk cycles; legal range 2..65535.
CNT_W, 8, width of the event count and result; legal range 2..16.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-low.
flag  input  1  event input from the detector stage; synchronous to clk.
enable  input  1  1 = run windows; 0 = idle and discard any partial window.
res_ready  input  1  consumer accepts the result when res_valid && res_ready.
res_valid  output  1  result register holds an unconsumed window result.
res_count  output  CNT_W  event count of the most recent completed window.
res_sat  output  1  count saturated at 2^CNT_W-1 during that window.
res_drop  output  1  sticky; at least one earlier result was overwritten before acceptance.

Behaviour:
- Reset (rst=0, async): state=IDLE, wcnt=0, ecnt=0, res_valid=0, res_count=0, res_sat=0, res_drop=0.
- FSM states: IDLE, RUN.
- IDLE -> RUN when enable=1. The first window cycle is the cycle after the transition, with wcnt=0.
- RUN -> IDLE when enable=0. Partial wcnt/ecnt are discarded (cleared). Result regs and handshake are untouched.
- In RUN, wcnt counts 0..WIN_LEN-1 and wraps. Windows are back-to-back with no gap cycle.
- Event per cycle: ev = flag (default build).
- ecnt increments on ev and saturates at 2^CNT_W-1. A sat bit is set if an increment is attempted at max.
- Window end (RUN, wcnt==WIN_LEN-1):
  - res_count <= sat(ecnt+ev).
  - res_sat <= sat bit, including this cycle.
  - res_valid <= 1.
  - ecnt and sat clear to 0. The next window starts with the next cycle.
- Latency: res_valid is high in the cycle immediately after the last window cycle.
- Handshake: res_valid stays high and res_count/res_sat stay stable until res_valid && res_ready. After acceptance, res_valid drops the next cycle.
- Simultaneous accept and window end: the new result loads, res_valid stays 1, res_drop is unchanged.
- Window end while res_valid=1 and res_ready=0: the old result is overwritten by the new one and res_drop <= 1.
- res_drop clears only on an accept with no overwrite in the same cycle.
- res_ready while res_valid=0: no effect.
- enable=0 during the window-end cycle: the window is aborted and no result is loaded.

Optional Feature:
Macro FLAG_WINDOW_EDGE_EN.
- Defined: ev = flag && !flag_d, where flag_d is a 1-cycle register of flag, reset 0, updating in all states. Counts rising edges, so a multi-cycle high flag counts once.
- Undefined: ev = flag and there is no flag_d register. Every high cycle counts.

Decomposition:
- Package flag_window_pkg holds the state typedef (IDLE, RUN) and localparam helpers: CNT_MAX = 2^CNT_W-1 and WCNT_W = clog2(WIN_LEN).
- The block is a single module. The optional edge detector is inline; a flag_edge_det sub-module is only justified if it is reused elsewhere.

Test Plan:
1. Reset mid-RUN (WIN_LEN=16, CNT_W=8): pulse rst low asynchronously -> all outputs 0 immediately; state=IDLE.
2. enable=1, flag high on 5 cycles in window 0, res_ready=1 -> res_valid high for 1 cycle, 17 cycles after the enable edge, with res_count=5 and res_sat=0. Window 1 with 0 flags -> res_count=0.
3. CNT_W=2, flag=1 for a full 16-cycle window -> res_count=3, res_sat=1. The next window with 2 flags -> res_count=2, res_sat=0.
4. res_ready=0 across two window ends (counts 4 then 7) -> res_count=7 and res_drop=1. Set res_ready=1 -> accepted, res_valid=0 and res_drop=0 the next cycle.
5. Accept asserted exactly on a window-end cycle -> new count loaded, res_valid stays 1, res_drop stays 0. Drop enable at wcnt=9 -> no result; re-enable -> a fresh window counts from 0.
6. FLAG_WINDOW_EDGE_EN defined, flag high for 6 consecutive cycles then 2 single pulses in one window -> res_count=3. Same stimulus with the macro undefined -> res_count=8.

Source files
------------

// File: rtl/flag_window_pkg.sv
// Shared types and sizing helpers for the flag window counter.
// No logic; sizing functions are evaluated at elaboration time.
// No handshake; imported by the counter top.
package flag_window_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Largest value an event count of width w can hold (2^w - 1).
   function automatic int unsigned cnt_max(input int unsigned w);
      return (32'd1 << w) - 32'd1;
   endfunction

   // Window counter width; a WIN_LEN of 2 still needs one bit.
   function automatic int unsigned wcnt_w(input int unsigned len);
      return (len > 32'd2) ? int'($clog2(len)) : 32'd1;
   endfunction

endpackage

// File: rtl/flag_window_counter.sv
// Counts flag events over back-to-back WIN_LEN windows; FLAG_WINDOW_EDGE_EN counts rising edges only.
// Latency: res_valid rises the cycle after the last window cycle.
// Backpressure: result held until res_ready; a new result overwrites an unaccepted one and sets res_drop.
module flag_window_counter
   import flag_window_pkg::*;
#(
   parameter int WIN_LEN = 16,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flag,
   input  logic             enable,
   input  logic             res_ready,
   output logic             res_valid,
   output logic [CNT_W-1:0] res_count,
   output logic             res_sat,
   output logic             res_drop
);

   localparam int unsigned      WCNT_W   = wcnt_w(WIN_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(cnt_max(CNT_W));
   localparam logic [WCNT_W-1:0] WIN_LAST = WCNT_W'(WIN_LEN - 1);

   state_t            state;
   state_t            state_nxt;
   logic [WCNT_W-1:0] wcnt;
   logic [CNT_W-1:0]  ecnt;
   logic              sat;
   logic              ev;
   logic              run_cyc;
   logic              win_end;
   logic [CNT_W-1:0]  ecnt_nxt;
   logic              sat_nxt;
   logic              accept;

`ifdef FLAG_WINDOW_EDGE_EN
   logic flag_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flag_d <= 1'b0;
      end else begin
         flag_d <= flag;
      end
   end

   assign ev = flag & ~flag_d;
`else
   assign ev = flag;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (enable)  state_nxt = RUN;
         RUN:     if (!enable) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A RUN cycle with enable low aborts: it neither counts nor ends a window.
   always_comb begin
      run_cyc = 1'b0;
      win_end = 1'b0;
      if (state == RUN && enable) begin
         run_cyc = 1'b1;
         win_end = (wcnt == WIN_LAST);
      end
   end

   always_comb begin
      ecnt_nxt = ecnt;
      sat_nxt  = sat;
      if (ev) begin
         if (ecnt == CNT_MAX) begin
            sat_nxt = 1'b1;
         end else begin
            ecnt_nxt = ecnt + CNT_W'(1);
         end
      end
   end

   assign accept = res_valid & res_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wcnt <= '0;
         ecnt <= '0;
         sat  <= 1'b0;
      end else if (!run_cyc || win_end) begin
         wcnt <= '0;
         ecnt <= '0;
         sat  <= 1'b0;
      end else begin
         wcnt <= wcnt + WCNT_W'(1);
         ecnt <= ecnt_nxt;
         sat  <= sat_nxt;
      end
   end

   // An accept coinciding with a window end hands over cleanly, so res_drop is left alone.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         res_valid <= 1'b0;
         res_count <= '0;
         res_sat   <= 1'b0;
         res_drop  <= 1'b0;
      end else if (win_end) begin
         res_valid <= 1'b1;
         res_count <= ecnt_nxt;
         res_sat   <= sat_nxt;
         if (res_valid && !res_ready) begin
            res_drop <= 1'b1;
         end
      end else if (accept) begin
         res_valid <= 1'b0;
         res_drop  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_flag_window_counter.sv
// Directed bench for flag_window_counter: two instances (CNT_W 8 and 2) share stimulus,
// expected window results are queued when driven and checked when the handshake accepts them.
module tb_flag_window_counter;
   import flag_window_pkg::*;

`ifdef FLAG_WINDOW_EDGE_EN
   localparam bit EDGE = 1'b1;
   localparam int EXP6 = 3;
`else
   localparam bit EDGE = 1'b0;
   localparam int EXP6 = 8;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       flag = 1'b0;
   logic       enable = 1'b0;
   logic       res_ready = 1'b0;
   logic       v8, s8, d8, v2, s2, d2;
   logic [7:0] c8;
   logic [1:0] c2;

   typedef struct packed {
      logic [7:0] count;
      logic       sat;
      logic       drop;
   } exp_t;

   exp_t q8[$];
   exp_t q2[$];
   int   checks = 0;
   int   errors = 0;
   logic prev_flag = 1'b0;
   logic pre_last_valid = 1'b0;
   int   last_n = 0;

   always #5 clk = ~clk;

   flag_window_counter #(.WIN_LEN(16), .CNT_W(8)) dut8 (
      .clk(clk), .rst(rst), .flag(flag), .enable(enable), .res_ready(res_ready),
      .res_valid(v8), .res_count(c8), .res_sat(s8), .res_drop(d8)
   );

   flag_window_counter #(.WIN_LEN(16), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .flag(flag), .enable(enable), .res_ready(res_ready),
      .res_valid(v2), .res_count(c2), .res_sat(s2), .res_drop(d2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare on accept (outputs stable since the previous negedge), then advance one cycle.
   task automatic tick();
      exp_t e;
      if (v8 && res_ready) begin
         chk("q8_has_entry", 32'(q8.size() != 0), 32'd1);
         if (q8.size() != 0) begin
            e = q8.pop_front();
            chk("count8", 32'(c8), 32'(e.count));
            chk("sat8", 32'(s8), 32'(e.sat));
            chk("drop8", 32'(d8), 32'(e.drop));
         end
      end
      if (v2 && res_ready) begin
         chk("q2_has_entry", 32'(q2.size() != 0), 32'd1);
         if (q2.size() != 0) begin
            e = q2.pop_front();
            chk("count2", 32'(c2), 32'(e.count));
            chk("sat2", 32'(s2), 32'(e.sat));
            chk("drop2", 32'(d2), 32'(e.drop));
         end
      end
      prev_flag = flag;
      @(posedge clk);
      @(negedge clk);
   endtask

   // One full 16-cycle window; bit i of pat is the flag in window cycle i.
   task automatic window(input logic [15:0] pat, input bit push, input bit drop_exp,
                         input bit rdy_mid, input bit rdy_last);
      int n = 0;
      for (int i = 0; i < 16; i++) begin
         if (i == 1) res_ready = rdy_mid;
         if (i == 15) res_ready = rdy_last;
         flag = pat[i];
         if (flag && (!EDGE || !prev_flag)) n++;
         if (i == 15) begin
            pre_last_valid = v8;
            last_n = n;
            if (push) begin
               q8.push_back('{count: 8'(n), sat: 1'b0, drop: drop_exp});
               q2.push_back('{count: 8'((n > 3) ? 3 : n), sat: (n > 3), drop: drop_exp});
            end
         end
         tick();
      end
      flag = 1'b0;
   endtask

   initial begin
      #2;
      chk("rst_valid", 32'(v8), 32'd0);
      chk("rst_count", 32'(c8), 32'd0);
      chk("rst_sat", 32'(s8), 32'd0);
      chk("rst_drop", 32'(d8), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // Basic count and first-result latency
      res_ready = 1'b1;
      enable = 1'b1;
      tick();
      window(16'h0155, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("lat_early_valid", 32'(pre_last_valid), 32'd0);
      chk("lat_valid", 32'(v8), 32'd1);
      window(16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("one_cycle_valid", 32'(pre_last_valid), 32'd0);

      // Saturation on the narrow instance, then sat clears
      window(16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1);
      window(16'h0024, 1'b1, 1'b0, 1'b1, 1'b1);

      // Two window ends without acceptance
      window(16'h1111, 1'b0, 1'b0, 1'b0, 1'b0);
      window(16'h1555, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("ovr_valid", 32'(v8), 32'd1);
      chk("ovr_count", 32'(c8), 32'(last_n));
      chk("ovr_drop", 32'(d8), 32'd1);
      chk("ovr_drop2", 32'(d2), 32'd1);
      enable = 1'b0;
      res_ready = 1'b1;
      tick();
      chk("acc_valid", 32'(v8), 32'd0);
      chk("acc_drop", 32'(d8), 32'd0);

      // Accept exactly on a window end
      enable = 1'b1;
      tick();
      window(16'h0009, 1'b1, 1'b0, 1'b1, 1'b0);
      window(16'h0410, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("sim_valid", 32'(v8), 32'd1);
      chk("sim_drop", 32'(d8), 32'd0);

      // Abort at wcnt=9, then a fresh window
      for (int i = 0; i < 9; i++) begin
         flag = i[0];
         tick();
      end
      enable = 1'b0;
      flag = 1'b1;
      tick();
      flag = 1'b0;
      tick();
      chk("abort_no_result", 32'(v8), 32'd0);
      enable = 1'b1;
      tick();
      window(16'h0101, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("fresh_valid", 32'(v8), 32'd1);

      // Long flag run followed by single pulses
      window(16'h02BF, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("edge_count", 32'(c8), 32'(EXP6));
      enable = 1'b0;
      tick();
      chk("q8_drained", 32'(q8.size()), 32'd0);
      chk("q2_drained", 32'(q2.size()), 32'd0);

      // Asynchronous reset while running with a pending, dropped result
      enable = 1'b1;
      tick();
      window(16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
      window(16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      chk("pre_rst_drop", 32'(d8), 32'd1);
      chk("pre_rst_sat2", 32'(s2), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_valid", 32'(v8), 32'd0);
      chk("arst_count", 32'(c8), 32'd0);
      chk("arst_drop", 32'(d8), 32'd0);
      chk("arst_sat2", 32'(s2), 32'd0);
      chk("arst_count2", 32'(c2), 32'd0);
      chk("arst_state", 32'(dut8.state), 32'(IDLE));
      enable = 1'b0;
      flag = 1'b0;
      prev_flag = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      tick();
      chk("post_rst_valid", 32'(v8), 32'd0);
      chk("post_rst_state", 32'(dut2.state), 32'(IDLE));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
